// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the hazard/stall controller.
//   sb_flags_t  : per-stage scoreboard flags (the register index is stored beside it,
//                 since its width follows the REG_AW parameter of the instance)
//   hz_state_e  : halt-drain FSM encoding (RUN / DRAIN / HALTED)
//   fwd_sel_w() : width of a forwarding select for a given tracked depth
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic valid;
    logic wr_en;
    logic is_load;
    logic halt;
  } sb_flags_t;

  localparam sb_flags_t SB_EMPTY = '{valid: 1'b0, wr_en: 1'b0, is_load: 1'b0, halt: 1'b0};

  // Select value 0 means "register file", 1..depth name a scoreboard entry.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage: holds, advances or is killed each cycle, and compares its
// destination against both decode source operands.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   hold_i               freeze this stage (memory stall)
//   kill_i               load an empty entry instead of flags_i (wrong-path squash)
//   flags_i, reg_i       entry arriving from the younger stage / decode
//   rs_i/rs_used_i       decode source A
//   rt_i/rt_used_i       decode source B
//   flags_o, reg_o       current contents
//   match_a_o/match_b_o  this entry produces the register decode reads
module hazard_sb_entry
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              hold_i,
  input  logic              kill_i,
  input  sb_flags_t         flags_i,
  input  logic [REG_AW-1:0] reg_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              rs_used_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              rt_used_i,
  output sb_flags_t         flags_o,
  output logic [REG_AW-1:0] reg_o,
  output logic              match_a_o,
  output logic              match_b_o
);

  sb_flags_t         flags_q, flags_d;
  logic [REG_AW-1:0] reg_q, reg_d;

  // Next-state selection: hold, squash or advance.
  always_comb begin
    flags_d = flags_q;
    reg_d   = reg_q;
    if (hold_i) begin
      flags_d = flags_q;
      reg_d   = reg_q;
    end else if (kill_i) begin
      flags_d = SB_EMPTY;
      reg_d   = reg_q;
    end else begin
      flags_d = flags_i;
      reg_d   = reg_i;
    end
  end

  // Stage storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= SB_EMPTY;
      reg_q   <= '0;
    end else begin
      flags_q <= flags_d;
      reg_q   <= reg_d;
    end
  end

  assign flags_o   = flags_q;
  assign reg_o     = reg_q;
  assign match_a_o = flags_q.valid & flags_q.wr_en & (reg_q == rs_i) & rs_used_i;
  assign match_b_o = flags_q.valid & flags_q.wr_en & (reg_q == rt_i) & rt_used_i;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the in-order pipeline, sitting beside decode.
// Tracks in-flight destinations in a PIPE_DEPTH-stage scoreboard (entry 0 = EX,
// entry PIPE_DEPTH-1 = WB) and produces load-use interlocks, forwarding selects,
// redirect flushes, memory-stall freeze and a halt-drain FSM.
// Optional feature: define PIPE_HAZARD_FWD_EN to enable forwarding; without it every
// RAW dependence stalls until the producer retires and the selects stay 0.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   dec_*_i                        decode instruction fields
//   redirect_i                     taken branch/jump resolved at REDIRECT_STG
//   mem_stall_i                    data memory busy, freezes everything
//   pc_write_o, ifid_write_o       PC / IF-ID may advance
//   flush_ifid_o, issue_bubble_o   squash IF-ID / issue a bubble into ID-EX
//   fwd_sel_a_o, fwd_sel_b_o       0 = regfile, k = result of entry k-1
//   halted_o                       pipeline drained after HALT (sticky)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int PIPE_DEPTH   = 3,
  parameter int LOAD_READY   = 2,
  parameter int REDIRECT_STG = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               dec_valid_i,
  input  logic [REG_AW-1:0]                  dec_rs_i,
  input  logic                               dec_rs_used_i,
  input  logic [REG_AW-1:0]                  dec_rt_i,
  input  logic                               dec_rt_used_i,
  input  logic                               dec_wr_en_i,
  input  logic [REG_AW-1:0]                  dec_wr_reg_i,
  input  logic                               dec_is_load_i,
  input  logic                               dec_halt_i,
  input  logic                               redirect_i,
  input  logic                               mem_stall_i,
  output logic                               pc_write_o,
  output logic                               ifid_write_o,
  output logic                               flush_ifid_o,
  output logic                               issue_bubble_o,
  output logic [fwd_sel_w(PIPE_DEPTH)-1:0]   fwd_sel_a_o,
  output logic [fwd_sel_w(PIPE_DEPTH)-1:0]   fwd_sel_b_o,
  output logic                               halted_o
);

  localparam int SEL_W = fwd_sel_w(PIPE_DEPTH);

  sb_flags_t         flags_s    [PIPE_DEPTH];
  logic [REG_AW-1:0] reg_s      [PIPE_DEPTH];
  sb_flags_t         in_flags_s [PIPE_DEPTH];
  logic [REG_AW-1:0] in_reg_s   [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] kill_s, match_a_s, match_b_s;

  logic             any_match_s, load_haz_s, stall_s, issue_s, bubble_s;
  logic             halt_leave_s, halt_kill_s;
  logic [SEL_W-1:0] sel_a_s, sel_b_s;
  hz_state_e        state_q;
  logic             halted_q;

  // Decode enters entry 0 only when it actually issues this cycle.
  assign issue_s = dec_valid_i & ~bubble_s & ~mem_stall_i;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_sb
    if (i == 0) begin : g_head
      assign in_flags_s[i] = issue_s ? '{valid: 1'b1, wr_en: dec_wr_en_i,
                                         is_load: dec_is_load_i, halt: dec_halt_i}
                                     : SB_EMPTY;
      assign in_reg_s[i]   = dec_wr_reg_i;
      assign kill_s[i]     = 1'b0;
    end else begin : g_tail
      assign in_flags_s[i] = flags_s[i-1];
      assign in_reg_s[i]   = reg_s[i-1];
      // Entries younger than the resolving stage are wrong-path and die as they advance.
      assign kill_s[i]     = redirect_i & ((i - 1) < REDIRECT_STG);
    end

    hazard_sb_entry #(.REG_AW(REG_AW)) u_entry (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .hold_i    (mem_stall_i),
      .kill_i    (kill_s[i]),
      .flags_i   (in_flags_s[i]),
      .reg_i     (in_reg_s[i]),
      .rs_i      (dec_rs_i),
      .rs_used_i (dec_rs_used_i),
      .rt_i      (dec_rt_i),
      .rt_used_i (dec_rt_used_i),
      .flags_o   (flags_s[i]),
      .reg_o     (reg_s[i]),
      .match_a_o (match_a_s[i]),
      .match_b_o (match_b_s[i])
    );
  end

  // Dependence scan, oldest to youngest so the youngest producer wins the select.
  // A producer at entry k is at entry k+1 when the consumer reaches EX, so a load
  // only interlocks while k+1 is still short of LOAD_READY.
  always_comb begin
    any_match_s = 1'b0;
    load_haz_s  = 1'b0;
    halt_kill_s = 1'b0;
    sel_a_s     = '0;
    sel_b_s     = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      any_match_s = any_match_s | match_a_s[k] | match_b_s[k];
      load_haz_s  = load_haz_s | ((match_a_s[k] | match_b_s[k]) & flags_s[k].is_load
                                  & ((k + 1) < LOAD_READY));
      halt_kill_s = halt_kill_s | (flags_s[k].valid & flags_s[k].halt & (k < REDIRECT_STG));
`ifdef PIPE_HAZARD_FWD_EN
      sel_a_s = match_a_s[k] ? SEL_W'(k + 1) : sel_a_s;
      sel_b_s = match_b_s[k] ? SEL_W'(k + 1) : sel_b_s;
`else
      sel_a_s = '0;
      sel_b_s = '0;
`endif
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  assign stall_s = dec_valid_i & load_haz_s;
`else
  assign stall_s = dec_valid_i & (any_match_s | load_haz_s);
`endif

  assign halt_leave_s = ~mem_stall_i & flags_s[PIPE_DEPTH-1].valid & flags_s[PIPE_DEPTH-1].halt;

  // Pipeline control priority: memory stall, halted, redirect, drain, interlock.
  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    flush_ifid_o = 1'b0;
    bubble_s     = 1'b0;
    if (mem_stall_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (state_q == ST_HALTED) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_s     = 1'b1;
    end else if (redirect_i) begin
      flush_ifid_o = 1'b1;
      bubble_s     = 1'b1;
    end else if ((state_q == ST_DRAIN) || stall_s) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_s     = 1'b1;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
    end
  end

  assign issue_bubble_o = bubble_s;
  assign fwd_sel_a_o    = sel_a_s;
  assign fwd_sel_b_o    = sel_b_s;

  // Halt-drain FSM with registered halted flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (issue_s && dec_halt_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (halt_leave_s) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (~mem_stall_i && redirect_i && halt_kill_s) begin
            state_q <= ST_RUN;
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted_o = halted_q;

endmodule
